// File: rtl/ibex_pkg_pext.sv
// Shared types for the P-extension multiplier: operand-size modes and the
// sequencer state encoding.
package ibex_pkg_pext;

    localparam int MULT_IMD_W = 64;

    typedef enum logic [1:0] {
        M8x8   = 2'b00,
        M16x16 = 2'b01,
        M32x16 = 2'b10,
        M32x32 = 2'b11
    } mult_pext_mode_e;

    typedef enum logic [1:0] {
        MSEQ_IDLE  = 2'b00,
        MSEQ_STEP1 = 2'b01,
        MSEQ_STEP2 = 2'b10
    } mult_seq_state_e;

endpackage

// File: rtl/ibex_mult_pext_seq.sv
// Cycle sequencer for the P-extension multiplier: steps the shared 17x17 array
// over the two A halves, accumulates into a 64-bit register and hands rd +/- product to the ALU.
module ibex_mult_pext_seq
    import ibex_pkg_pext::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mult_en_i,
    input  mult_pext_mode_e       mult_mode_i,
    input  logic [1:0]            cycle_count_i,
    input  logic                  accum_i,
    input  logic [1:0]            accum_sub_i,
    input  logic                  res_hi_i,
    input  logic [31:0]           rd_i,
    input  logic [MULT_IMD_W-1:0] partial_i,
    output logic                  step_o,
    output logic [MULT_IMD_W-1:0] imd_o,
    output logic                  alu_req_o,
    output logic [31:0]           alu_operand_a_o,
    output logic [31:0]           alu_operand_b_o,
    output logic                  alu_sub_o,
    input  logic [31:0]           alu_result_i,
    output logic [MULT_IMD_W-1:0] product_o,
    output logic [31:0]           result_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    mult_seq_state_e       state_q, state_d;
    logic [MULT_IMD_W-1:0] imd_q, imd_d;
    logic [MULT_IMD_W-1:0] sum;
    logic [31:0]           word;
    logic                  sub;

    // Upper-half partial is weighted by 2^16 relative to the lower half.
    assign sum  = imd_q + {partial_i[MULT_IMD_W-17:0], 16'b0};
    assign word = res_hi_i ? imd_q[63:32] : imd_q[31:0];
    assign sub  = accum_sub_i[1];

    always_comb begin
        state_d         = state_q;
        imd_d           = imd_q;
        step_o          = 1'b0;
        alu_req_o       = 1'b0;
        alu_operand_a_o = 32'b0;
        alu_operand_b_o = 32'b0;
        alu_sub_o       = 1'b0;
        product_o       = '0;
        result_o        = 32'b0;
        valid_o         = 1'b0;

        unique case (state_q)
            MSEQ_IDLE: begin
                if (mult_en_i) begin
                    if (cycle_count_i == 2'b00) begin
                        product_o = partial_i;
                        valid_o   = 1'b1;
                    end else begin
                        imd_d   = partial_i;
                        state_d = MSEQ_STEP1;
                    end
                end
            end
            MSEQ_STEP1: begin
                if (!mult_en_i) begin
                    state_d = MSEQ_IDLE;
                end else begin
                    step_o = 1'b1;
                    if (cycle_count_i == 2'b01) begin
                        product_o = sum;
                        valid_o   = 1'b1;
                        state_d   = MSEQ_IDLE;
                    end else begin
                        // 2'b10 is illegal and falls through to the 3-cycle path.
                        imd_d   = sum;
                        state_d = MSEQ_STEP2;
                    end
                end
            end
            MSEQ_STEP2: begin
                state_d = MSEQ_IDLE;
                if (mult_en_i) begin
                    alu_req_o       = 1'b1;
                    alu_operand_a_o = rd_i;
                    alu_operand_b_o = sub ? ~word : word;
                    alu_sub_o       = sub;
                    result_o        = alu_result_i;
                    valid_o         = 1'b1;
                end
            end
            default: state_d = MSEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MSEQ_IDLE;
            imd_q   <= '0;
        end else begin
            state_q <= state_d;
            imd_q   <= imd_d;
        end
    end

    assign imd_o  = imd_q;
    assign busy_o = (state_q != MSEQ_IDLE);

    a_cc_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mult_en_i |-> cycle_count_i != 2'b10);

    a_short_modes_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mult_en_i && mult_mode_i != M32x32) |-> cycle_count_i == 2'b00);

    a_accum_three_cycle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mult_en_i && accum_i) |-> cycle_count_i == 2'b11);

    a_ctrl_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (busy_o && mult_en_i) |-> ($stable(mult_mode_i) && $stable(cycle_count_i) &&
                                   $stable(accum_i) && $stable(accum_sub_i) &&
                                   $stable(res_hi_i) && $stable(rd_i)));

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Directed bench for the P-extension multiplier sequencer; expected values are hand-computed.
module tb_ibex_mult_pext_seq;
    import ibex_pkg_pext::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mult_en;
    mult_pext_mode_e mult_mode;
    logic [1:0]      cycle_count;
    logic            accum;
    logic [1:0]      accum_sub;
    logic            res_hi;
    logic [31:0]     rd;
    logic [63:0]     partial;
    logic            step;
    logic [63:0]     imd;
    logic            alu_req;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic            alu_sub;
    logic [31:0]     alu_result;
    logic [63:0]     product;
    logic [31:0]     result;
    logic            valid;
    logic            busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ibex_mult_pext_seq dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .mult_en_i      (mult_en),
        .mult_mode_i    (mult_mode),
        .cycle_count_i  (cycle_count),
        .accum_i        (accum),
        .accum_sub_i    (accum_sub),
        .res_hi_i       (res_hi),
        .rd_i           (rd),
        .partial_i      (partial),
        .step_o         (step),
        .imd_o          (imd),
        .alu_req_o      (alu_req),
        .alu_operand_a_o(alu_a),
        .alu_operand_b_o(alu_b),
        .alu_sub_o      (alu_sub),
        .alu_result_i   (alu_result),
        .product_o      (product),
        .result_o       (result),
        .valid_o        (valid),
        .busy_o         (busy)
    );

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++;
        if (imd !== 64'h0) begin bad++; $display("FAIL reset_imd got %h want 0", imd); end
        total++;
        if ({valid, alu_req, step, product, result} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b req=%b step=%b prod=%h res=%h want all 0",
                     valid, alu_req, step, product, result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        @(negedge clk);
        mult_mode = M16x16; cycle_count = 2'b00; accum = 1'b0; accum_sub = 2'b00;
        partial = 64'h0000_0000_1234_0000; mult_en = 1'b1;
        #1;
        total++;
        if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", valid); end
        total++;
        if (product !== 64'h0000_0000_1234_0000) begin
            bad++; $display("FAIL single_product got %h want 0000000012340000", product);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got %b want 0", busy); end
        @(negedge clk);
        mult_en = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++; $display("FAIL single_after got busy=%b valid=%b want 0/0", busy, valid);
        end
    endtask

    task automatic test_smmul();
        int pulses;
        pulses = 0;
        @(negedge clk);
        mult_mode = M32x32; cycle_count = 2'b01; accum = 1'b0; res_hi = 1'b1;
        partial = 64'h0; mult_en = 1'b1;
        #1;
        if (valid) pulses++;
        total++;
        if (step !== 1'b0) begin bad++; $display("FAIL smmul_step0 got %b want 0", step); end
        @(negedge clk);
        partial = 64'h0000_4000_0000_0000;
        #1;
        if (valid) pulses++;
        total++;
        if (step !== 1'b1) begin bad++; $display("FAIL smmul_step1 got %b want 1", step); end
        total++;
        if (product !== 64'h4000_0000_0000_0000 || valid !== 1'b1) begin
            bad++; $display("FAIL smmul_product got %h valid=%b want 4000000000000000 valid=1",
                            product, valid);
        end
        @(negedge clk);
        mult_en = 1'b0;
        #1;
        if (valid) pulses++;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL smmul_idle got busy=%b want 0", busy); end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL smmul_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_kmmac();
        @(negedge clk);
        mult_mode = M32x32; cycle_count = 2'b11; accum = 1'b1; accum_sub = 2'b00; res_hi = 1'b1;
        rd = 32'h0000_0010; partial = 64'h0; mult_en = 1'b1;
        @(negedge clk);
        partial = 64'h0000_0000_0005_0000;
        #1;
        total++;
        if (valid !== 1'b0 || alu_req !== 1'b0) begin
            bad++; $display("FAIL kmmac_step1 got valid=%b req=%b want 0/0", valid, alu_req);
        end
        @(negedge clk);
        partial = 64'h0;
        alu_result = 32'h0000_0015;
        #1;
        total++;
        if (imd !== 64'h0000_0005_0000_0000) begin
            bad++; $display("FAIL kmmac_imd got %h want 0000000500000000", imd);
        end
        total++;
        if (alu_req !== 1'b1 || alu_a !== 32'h10 || alu_b !== 32'h5 || alu_sub !== 1'b0) begin
            bad++; $display("FAIL kmmac_alu got req=%b a=%h b=%h sub=%b want 1/10/5/0",
                            alu_req, alu_a, alu_b, alu_sub);
        end
        total++;
        if (result !== 32'h15 || valid !== 1'b1) begin
            bad++; $display("FAIL kmmac_result got %h valid=%b want 15 valid=1", result, valid);
        end
        @(negedge clk);
        mult_en = 1'b0; accum = 1'b0;
        #1;
        total++;
        if (alu_req !== 1'b0 || alu_a !== 32'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL kmmac_release got req=%b a=%h busy=%b want 0/0/0",
                            alu_req, alu_a, busy);
        end
    endtask

    task automatic test_msubr32();
        @(negedge clk);
        mult_mode = M32x32; cycle_count = 2'b11; accum = 1'b1; accum_sub = 2'b10; res_hi = 1'b0;
        rd = 32'd100; partial = 64'h7; mult_en = 1'b1;
        @(negedge clk);
        partial = 64'h0000_0000_0001_0000;
        @(negedge clk);
        partial = 64'h0;
        alu_result = 32'd93;
        #1;
        total++;
        if (imd !== 64'h0000_0001_0000_0007) begin
            bad++; $display("FAIL msubr_imd got %h want 0000000100000007", imd);
        end
        total++;
        if (alu_b !== 32'hFFFF_FFF8 || alu_sub !== 1'b1 || alu_a !== 32'd100) begin
            bad++; $display("FAIL msubr_alu got a=%h b=%h sub=%b want 00000064/fffffff8/1",
                            alu_a, alu_b, alu_sub);
        end
        total++;
        if (result !== 32'd93) begin
            bad++; $display("FAIL msubr_result got %0d want 93", result);
        end
        @(negedge clk);
        mult_en = 1'b0; accum = 1'b0; accum_sub = 2'b00;
    endtask

    task automatic test_kill_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        mult_mode = M32x32; cycle_count = 2'b01; res_hi = 1'b1;
        partial = 64'h1234; mult_en = 1'b1;
        @(negedge clk);
        mult_en = 1'b0;
        #1;
        if (valid) pulses++;
        total++;
        if (busy !== 1'b1 || step !== 1'b0) begin
            bad++; $display("FAIL kill_step1 got busy=%b step=%b want 1/0", busy, step);
        end
        @(negedge clk);
        #1;
        if (valid) pulses++;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle got busy=%b want 0", busy); end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL kill_valid got %0d pulses want 0", pulses); end
        partial = 64'h10; mult_en = 1'b1;
        @(negedge clk);
        partial = 64'h1;
        #1;
        total++;
        if (product !== 64'h0000_0000_0001_0010 || valid !== 1'b1) begin
            bad++; $display("FAIL b2b_product got %h valid=%b want 0000000000010010 valid=1",
                            product, valid);
        end
        @(negedge clk);
        mult_en = 1'b0;
    endtask

    task automatic test_async_reset_step2();
        @(negedge clk);
        mult_mode = M32x32; cycle_count = 2'b11; accum = 1'b1; accum_sub = 2'b00; res_hi = 1'b1;
        rd = 32'h20; partial = 64'h0000_0000_0003_0000; mult_en = 1'b1;
        @(negedge clk);
        partial = 64'h0000_0000_0003_0000;
        @(negedge clk);
        #1;
        total++;
        if (alu_req !== 1'b1 || imd !== 64'h0000_0003_0003_0000) begin
            bad++; $display("FAIL arst_pre got req=%b imd=%h want 1/0000000300030000", alu_req, imd);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (alu_req !== 1'b0 || valid !== 1'b0) begin
            bad++; $display("FAIL arst_outputs got req=%b valid=%b want 0/0", alu_req, valid);
        end
        total++;
        if (imd !== 64'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL arst_state got imd=%h busy=%b want 0/0", imd, busy);
        end
        @(negedge clk);
        mult_en = 1'b0; accum = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++; $display("FAIL arst_after got busy=%b valid=%b want 0/0", busy, valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; mult_en = 1'b0; mult_mode = M8x8; cycle_count = 2'b00;
        accum = 1'b0; accum_sub = 2'b00; res_hi = 1'b0; rd = 32'h0;
        partial = 64'h0; alu_result = 32'h0;
        test_reset();
        test_single_cycle();
        test_smmul();
        test_kmmac();
        test_msubr32();
        test_kill_back_to_back();
        test_async_reset_step2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
